// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control: sequencer states and
// register-file addressing constants.
package core_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam int RA_W = 5;
    localparam logic [RA_W-1:0] REG_X0 = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, branch
// flushes, memory-wait freezes with timeout-to-halt, and perf counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int RA_W        = core_pkg::RA_W,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_ra1,
    input  logic [RA_W-1:0]  id_ra2,
    input  logic             id_use_ra1,
    input  logic             id_use_ra2,
    input  logic             ex_memRead,
    input  logic [RA_W-1:0]  ex_wa,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    state_t            state, state_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic              waiting, load_use, freeze, branch_flush;
    logic              stall_inc, flush_inc;

    assign waiting  = mem_req && !mem_ready;
    assign load_use = ex_memRead && (ex_wa != RA_W'(REG_X0)) &&
                      ((id_use_ra1 && (id_ra1 == ex_wa)) ||
                       (id_use_ra2 && (id_ra2 == ex_wa)));
    assign halted   = (state == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
        end
    end

    always_comb begin
        state_n       = state;
        wait_n        = wait_cnt;
        freeze        = 1'b0;
        branch_flush  = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;

        case (state)
            RUN: begin
                if (waiting) begin
                    freeze  = 1'b1;
                    state_n = MEM_WAIT;
                    wait_n  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (waiting) begin
                    freeze = 1'b1;
                    if (wait_cnt == TIMEOUT_V) begin
                        state_n = HALT;
                    end else begin
                        wait_n = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    // Access finished: this cycle behaves as RUN so held events act now.
                    state_n = RUN;
                    wait_n  = '0;
                end
            end
            HALT: begin
                freeze = 1'b1;
            end
            default: begin
                state_n = RUN;
                wait_n  = '0;
            end
        endcase

        if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_hold    = 1'b1;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            // The ID instruction is discarded, so any load-use on it is moot.
            branch_flush = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end

        if (rst) begin
            branch_flush  = 1'b0;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_hold    = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end
    end

    assign stall_inc = !rst && !halted && !pc_en;
    assign flush_inc = !rst && branch_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule
